// File: rtl/bus_pkg.sv
// bus_pkg: arbitration state, source index type and shared bus constants (also used by the legacy bus mux)
package bus_pkg;
  typedef enum logic {IDLE, OWN} arb_state_t;
  localparam int DEF_REG_WIDTH = 12;
  localparam int DEF_N_SRC = 4;
  localparam int DEF_MAX_HOLD = 8;
  typedef logic [$clog2(DEF_N_SRC)-1:0] src_idx_t;
  localparam src_idx_t SEL_DEFAULT = '0;
  localparam logic [DEF_REG_WIDTH-1:0] BUS_ZERO = '0;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational winner search, round-robin from ptr+1; ARB_FIXED_PRIO_EN selects lowest-index winner
module rr_picker #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         any
);
`ifdef ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[k]) begin
        idx = W'(k);
        any = 1'b1;
      end
    end
    onehot = any ? N'(1) << idx : '0;
  end
`else
  logic [W-1:0] j;
  // scan farthest-first so the nearest requester after ptr is the last assignment
  always_comb begin
    idx = '0;
    any = 1'b0;
    j = '0;
    for (int k = N; k >= 1; k--) begin
      j = W'((int'(ptr) + k) % N);
      if (req[j]) begin
        idx = j;
        any = 1'b1;
      end
    end
    onehot = any ? N'(1) << idx : '0;
  end
`endif
endmodule

// File: rtl/bus_arbiter_mux.sv
// bus_arbiter_mux: registered N-source bus mux with round-robin arbitration and hold limit
// ARB_FIXED_PRIO_EN switches the picker to fixed lowest-index priority.
module bus_arbiter_mux
  import bus_pkg::*;
#(
  parameter int REG_WIDTH = DEF_REG_WIDTH,
  parameter int N_SRC = DEF_N_SRC,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  localparam int SEL_WIDTH = $clog2(N_SRC)
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic [N_SRC-1:0]           req,
  input  logic [N_SRC*REG_WIDTH-1:0] dataIn,
  output logic [N_SRC-1:0]           grant,
  output logic [SEL_WIDTH-1:0]       busOwner,
  output logic                       busValid,
  output logic [REG_WIDTH-1:0]       busOut
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD);
  arb_state_t state_q, state_d;
  logic [N_SRC-1:0] grant_q, grant_d;
  logic [SEL_WIDTH-1:0] owner_q, owner_d, rr_q, rr_d;
  logic [REG_WIDTH-1:0] bus_q, bus_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [REG_WIDTH-1:0] src [N_SRC];
  logic [N_SRC-1:0] mask, win_oh;
  logic [SEL_WIDTH-1:0] win_idx;
  logic any, own_req, sw, go_idle;
  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    assign src[i] = dataIn[i*REG_WIDTH +: REG_WIDTH];
  end
  // grant_q is zero in IDLE, so this excludes the owner only while one exists
  assign mask = req & ~grant_q;
  rr_picker #(.N(N_SRC), .W(SEL_WIDTH)) u_pick (
    .req(mask), .ptr(rr_q), .onehot(win_oh), .idx(win_idx), .any(any)
  );
  assign own_req = req[owner_q];
  assign sw = any && (state_q == IDLE || !own_req || hold_q == HMAX);
  assign go_idle = !sw && (state_q == IDLE || !own_req);
  always_comb begin
    state_d = sw ? OWN : go_idle ? IDLE : state_q;
    grant_d = sw ? win_oh : go_idle ? '0 : grant_q;
    owner_d = sw ? win_idx : owner_q;
    rr_d = sw ? win_idx : rr_q;
    bus_d = sw ? src[win_idx] : go_idle ? BUS_ZERO : src[owner_q];
    hold_d = sw ? HW'(1) : go_idle ? '0 : (hold_q == HMAX ? hold_q : hold_q + 1'b1);
  end
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= SEL_WIDTH'(SEL_DEFAULT);
      rr_q <= SEL_WIDTH'(N_SRC - 1);
      bus_q <= '0;
      hold_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      rr_q <= rr_d;
      bus_q <= bus_d;
      hold_q <= hold_d;
    end
  end
  assign grant = grant_q;
  assign busOwner = owner_q;
  assign busValid = |grant_q;
  assign busOut = bus_q;
endmodule

// File: tb/tb_bus_arbiter_mux.sv
// tb_bus_arbiter_mux: random + directed stimulus, behavioural model feeding a scoreboard queue
module tb_bus_arbiter_mux;
  localparam int N = 4;
  localparam int RW = 12;
  localparam int MH = 4;
  logic clk = 1'b0;
  logic rstN;
  logic [N-1:0] req = '0;
  logic [N*RW-1:0] dataIn = '0;
  logic [N-1:0] grant;
  logic [1:0] busOwner;
  logic busValid;
  logic [RW-1:0] busOut;
  int n_chk = 0;
  int n_pass = 0;
  logic [18:0] sb [$];
  int m_owner = 0;
  bit m_valid = 0;
  logic [RW-1:0] m_bus = '0;
  int m_hold = 0;
  int m_ptr = N - 1;

  bus_arbiter_mux #(.REG_WIDTH(RW), .N_SRC(N), .MAX_HOLD(MH)) dut (
    .clk(clk), .rstN(rstN), .req(req), .dataIn(dataIn),
    .grant(grant), .busOwner(busOwner), .busValid(busValid), .busOut(busOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int pick(input logic [N-1:0] r, input int excl, input int ptr);
`ifdef ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (r[i] && i != excl) return i;
`else
    for (int k = 1; k <= N; k++) begin
      int i = (ptr + k) % N;
      if (r[i] && i != excl) return i;
    end
`endif
    return -1;
  endfunction

  function automatic logic [RW-1:0] din(input int i);
    return dataIn[i*RW +: RW];
  endfunction

  function automatic void give(input int w);
    m_owner = w;
    m_valid = 1;
    m_bus = din(w);
    m_hold = 1;
    m_ptr = w;
  endfunction

  // Reference model: one bus transaction decision per rising edge
  always @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      m_owner = 0; m_valid = 0; m_bus = '0; m_hold = 0; m_ptr = N - 1;
      sb.delete();
    end else begin
      int o;
      if (!m_valid) begin
        o = pick(req, -1, m_ptr);
        if (o >= 0) give(o);
      end else begin
        o = pick(req, m_owner, m_ptr);
        if (!req[m_owner]) begin
          if (o >= 0) give(o);
          else begin m_valid = 0; m_bus = '0; end
        end else if (o >= 0 && m_hold == MH) give(o);
        else begin
          m_bus = din(m_owner);
          if (m_hold < MH) m_hold++;
        end
      end
      sb.push_back({m_valid ? 4'(1 << m_owner) : 4'b0, 2'(m_owner), m_valid, m_bus});
    end
  end

  // Monitor: compares DUT state just after each edge with the oldest expectation
  always @(posedge clk) begin
    #1;
    if (!rstN) chk("reset_hold", {13'b0, grant, busOwner, busValid, busOut}, 32'h0);
    else if (sb.size() == 0) begin
      n_chk++;
      $display("FAIL sb_empty: no expectation queued for DUT output");
    end else chk("scoreboard", {13'b0, grant, busOwner, busValid, busOut}, {13'b0, sb.pop_front()});
  end

  task automatic drive(input logic [N-1:0] r);
    @(negedge clk);
    req = r;
    dataIn = {$urandom, $urandom};
  endtask

  task automatic reset_pulse(input logic [N-1:0] r_after);
    @(negedge clk);
    #2 rstN = 1'b0;
    #1 chk("async_reset", {13'b0, grant, busOwner, busValid, busOut}, 32'h0);
    @(negedge clk);
    rstN = 1'b1;
    req = r_after;
  endtask

  initial begin
    rstN = 1'b0;
    #12 chk("reset_state", {13'b0, grant, busOwner, busValid, busOut}, 32'h0);
    @(negedge clk);
    rstN = 1'b1;
    drive(4'b0100);
    dataIn[2*RW +: RW] = 12'hABC;
    @(negedge clk);
    chk("single_grant", {13'b0, grant, busOwner, busValid, busOut}, {13'b0, 4'b0100, 2'd2, 1'b1, 12'hABC});
    dataIn[2*RW +: RW] = 12'h123;
    @(negedge clk);
    chk("data_follow", 32'(busOut), 32'h123);
    drive(4'b0000);
    reset_pulse(4'b1111);
    for (int k = 0; k < N; k++) begin
      @(negedge clk);
      chk("b2b_grant", {27'b0, busValid, grant}, {27'b0, 1'b1, 4'(1 << k)});
      req = 4'(4'b1111 << (k + 1));
    end
    @(negedge clk);
    chk("drop_idle", {13'b0, grant, busOwner, busValid, busOut}, {13'b0, 4'b0, 2'd3, 1'b0, 12'h0});
    for (int c = 0; c < 20; c++) drive(4'b0011);
    drive(4'b0000);
    reset_pulse(4'b0000);
    drive(4'b0100);
    drive(4'b0110);
    drive(4'b0110);
    reset_pulse(4'b0110);
    @(negedge clk);
    chk("post_reset_winner", {28'b0, grant}, 32'b0010);
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) drive(4'($urandom));
      else drive(req);
      if ($urandom_range(0, 119) == 0) reset_pulse(4'($urandom));
    end
    drive(4'b0000);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
